// File: rtl/dm_store_buffer.sv
// Posted-write store buffer between MEM-stage stores/loads and the single-port data memory.
// Define DM_SB_FWD_EN to forward loads from queued stores; otherwise matching loads stall until drained.
module dm_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [31:0]      st_pc,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_addr,
  output logic [31:0]      ld_data,
  output logic             ld_hit,
  output logic             dm_MemWrite,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_writeData,
  output logic [31:0]      dm_PC,
  input  logic [31:0]      dm_readData,
  input  logic             flush_req,
  output logic             flush_done,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    S_NORMAL = 2'd0,
    S_FLUSH  = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  entry_t             entries [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  state_t             state;
  state_t             state_nxt;

  logic               push;
  logic               pop;
  logic               any_match;
  logic               ld_block;
  entry_t             head;

  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign st_ready   = !full && (state == S_NORMAL);
  assign flush_done = (state == S_DONE);
  assign push       = st_valid && st_ready;
  assign pop        = dm_MemWrite;
  assign head       = entries[rd_ptr];

`ifdef DM_SB_FWD_EN
  logic [31:0] fwd_data;

  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    any_match = 1'b0;
    fwd_data  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[rd_ptr + PTR_W'(i)] &&
          entries[rd_ptr + PTR_W'(i)].addr[31:2] == ld_addr[31:2]) begin
        any_match = 1'b1;
        fwd_data  = entries[rd_ptr + PTR_W'(i)].data;
      end
    end
  end

  assign ld_block = 1'b0;
  assign ld_hit   = ld_valid && any_match;
  assign ld_data  = any_match ? fwd_data : dm_readData;
`else
  // Any word-address match means dm is stale for this load.
  always_comb begin
    any_match = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && entries[i].addr[31:2] == ld_addr[31:2]) begin
        any_match = 1'b1;
      end
    end
  end

  assign ld_block = ld_valid && any_match;
  assign ld_hit   = 1'b0;
  assign ld_data  = dm_readData;
`endif

  // Memory port arbitration: full buffer or blocked load forces a drain, else loads win.
  always_comb begin
    dm_MemWrite  = 1'b0;
    dm_addr      = '0;
    dm_writeData = '0;
    dm_PC        = '0;
    ld_ready     = !full && !ld_block;
    if (full || ld_block) begin
      dm_MemWrite  = 1'b1;
      dm_addr      = head.addr;
      dm_writeData = head.data;
      dm_PC        = head.pc;
    end else if (ld_valid) begin
      dm_addr      = ld_addr;
    end else if (!empty) begin
      dm_MemWrite  = 1'b1;
      dm_addr      = head.addr;
      dm_writeData = head.data;
      dm_PC        = head.pc;
    end
  end

  // Flush sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      S_NORMAL: if (flush_req) state_nxt = S_FLUSH;
      S_FLUSH:  if (empty)     state_nxt = S_DONE;
      S_DONE:                  state_nxt = S_NORMAL;
      default:                 state_nxt = S_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Queue control: pointers, occupancy and valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        wr_ptr          <= wr_ptr + PTR_W'(1);
        valid_q[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + PTR_W'(1);
        valid_q[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_ptr] <= '{addr: st_addr, data: st_data, pc: st_pc};
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer with a drain scoreboard and a small word memory model.
module tb_dm_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             st_valid;
  logic             st_ready;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [31:0]      st_pc;
  logic             ld_valid;
  logic             ld_ready;
  logic [31:0]      ld_addr;
  logic [31:0]      ld_data;
  logic             ld_hit;
  logic             dm_MemWrite;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_writeData;
  logic [31:0]      dm_PC;
  logic [31:0]      dm_readData;
  logic             flush_req;
  logic             flush_done;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;

  dm_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_pc        (st_pc),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_hit       (ld_hit),
    .dm_MemWrite  (dm_MemWrite),
    .dm_addr      (dm_addr),
    .dm_writeData (dm_writeData),
    .dm_PC        (dm_PC),
    .dm_readData  (dm_readData),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  always #5 clk = ~clk;

  // Word memory standing in for dm: combinational read, write at the clock edge.
  logic [31:0] dmem [64];
  assign dm_readData = dmem[dm_addr[7:2]];
  always @(posedge clk) if (dm_MemWrite) dmem[dm_addr[7:2]] <= dm_writeData;

  int          errs = 0;
  int          checks = 0;
  int          wr_cnt = 0;
  int          w0;
  logic [95:0] sb_q [$];
  logic [95:0] mon_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_pc    = p;
  endtask

  task automatic drain_wait(input string tag);
    int n = 0;
    while (!empty && n < 32) begin
      tick();
      n++;
    end
    chk(tag, 32'(empty), 32'd1);
  endtask

  // Every dm write must match the oldest accepted store; accepted stores are queued here.
  always @(negedge clk) begin
    if (reset) begin
      if (dm_MemWrite) begin
        wr_cnt++;
        checks++;
        assert (sb_q.size() != 0) else begin
          errs++;
          $error("FAIL unexpected_write observed addr=0x%0h expected=no write", dm_addr);
        end
        if (sb_q.size() != 0) begin
          mon_exp = sb_q.pop_front();
          chk("drain_addr", dm_addr, mon_exp[95:64]);
          chk("drain_data", dm_writeData, mon_exp[63:32]);
          chk("drain_pc", dm_PC, mon_exp[31:0]);
        end
      end
      if (st_valid && st_ready) sb_q.push_back({st_addr, st_data, st_pc});
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
    ld_valid = 1'b0; ld_addr = '0; flush_req = 1'b0;

    // Reset state
    tick(); tick();
    samp();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_memwrite", 32'(dm_MemWrite), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_ld_hit", 32'(ld_hit), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    tick();
    reset = 1'b1;

    // Two back-to-back stores drain in order
    store(32'h0, 32'h1, 32'h100);
    samp();
    chk("t1_st_ready", 32'(st_ready), 32'd1);
    chk("t1_nowrite", 32'(dm_MemWrite), 32'd0);
    tick();
    store(32'h4, 32'h3, 32'h104);
    samp();
    chk("t1_count_a", 32'(count), 32'd1);
    chk("t1_wr_a", 32'(dm_MemWrite), 32'd1);
    chk("t1_addr_a", dm_addr, 32'h0);
    tick();
    st_valid = 1'b0;
    samp();
    chk("t1_wr_b", 32'(dm_MemWrite), 32'd1);
    chk("t1_addr_b", dm_addr, 32'h4);
    tick();
    samp();
    chk("t1_wr_end", 32'(dm_MemWrite), 32'd0);
    chk("t1_count_end", 32'(count), 32'd0);
    chk("t1_empty_end", 32'(empty), 32'd1);
    tick();

    // Fill to full while a non-matching load holds the port
    ld_valid = 1'b1; ld_addr = 32'h0;
    for (int k = 0; k < 4; k++) begin
      store(32'h20 + 32'(4 * k), 32'h50 + 32'(k), 32'h200 + 32'(4 * k));
      samp();
      chk("t2_ld_ready", 32'(ld_ready), 32'd1);
      chk("t2_ld_data", ld_data, 32'h1);
      chk("t2_nowrite", 32'(dm_MemWrite), 32'd0);
      tick();
    end
    st_valid = 1'b0;
    samp();
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_st_ready", 32'(st_ready), 32'd0);
    chk("t2_count4", 32'(count), 32'd4);
    chk("t2_ld_stall", 32'(ld_ready), 32'd0);
    chk("t2_drain_wr", 32'(dm_MemWrite), 32'd1);
    chk("t2_drain_addr", dm_addr, 32'h20);
    tick();
    samp();
    chk("t2_count3", 32'(count), 32'd3);
    chk("t2_ld_resume", 32'(ld_ready), 32'd1);
    chk("t2_ld_port", 32'(dm_MemWrite), 32'd0);
    tick();
    ld_valid = 1'b0;
    drain_wait("t2_drain_empty");

    // Two stores to the same word, then a load of that word
    ld_valid = 1'b1; ld_addr = 32'h40;
    store(32'h10, 32'hAA, 32'h300);
    samp(); tick();
    store(32'h10, 32'hBB, 32'h304);
    samp(); tick();
    st_valid = 1'b0; ld_addr = 32'h12;
    samp();
    chk("t3_count2", 32'(count), 32'd2);
`ifdef DM_SB_FWD_EN
    chk("t3_ld_ready", 32'(ld_ready), 32'd1);
    chk("t3_ld_hit", 32'(ld_hit), 32'd1);
    chk("t3_ld_data", ld_data, 32'hBB);
    chk("t3_nowrite", 32'(dm_MemWrite), 32'd0);
    tick();
    ld_valid = 1'b0;
    drain_wait("t3_drain_empty");
    ld_valid = 1'b1;
    samp();
    chk("t3_post_hit", 32'(ld_hit), 32'd0);
    chk("t3_post_data", ld_data, 32'hBB);
    tick();
    ld_valid = 1'b0;
`else
    chk("t3_stall_a", 32'(ld_ready), 32'd0);
    chk("t3_ld_hit", 32'(ld_hit), 32'd0);
    chk("t3_drain_a", 32'(dm_MemWrite), 32'd1);
    chk("t3_data_a", dm_writeData, 32'hAA);
    tick();
    samp();
    chk("t3_stall_b", 32'(ld_ready), 32'd0);
    chk("t3_data_b", dm_writeData, 32'hBB);
    chk("t3_count1", 32'(count), 32'd1);
    tick();
    samp();
    chk("t3_ld_ready", 32'(ld_ready), 32'd1);
    chk("t3_ld_data", ld_data, 32'hBB);
    chk("t3_ld_hit_end", 32'(ld_hit), 32'd0);
    chk("t3_empty", 32'(empty), 32'd1);
    tick();
    ld_valid = 1'b0;
`endif

    // Steady push+pop at count=2 across pointer wrap
    ld_valid = 1'b1; ld_addr = 32'h40;
    store(32'h80, 32'h60, 32'h400);
    samp(); tick();
    store(32'h84, 32'h61, 32'h404);
    samp(); tick();
    ld_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      store(32'h88 + 32'(4 * k), 32'h62 + 32'(k), 32'h408 + 32'(4 * k));
      samp();
      chk("t4_count2", 32'(count), 32'd2);
      chk("t4_wr", 32'(dm_MemWrite), 32'd1);
      tick();
    end
    st_valid = 1'b0;
    drain_wait("t4_drain_empty");

    // Flush with three queued entries
    ld_valid = 1'b1; ld_addr = 32'h40;
    for (int k = 0; k < 3; k++) begin
      store(32'hC0 + 32'(4 * k), 32'h70 + 32'(k), 32'h500 + 32'(4 * k));
      samp(); tick();
    end
    st_valid = 1'b0; ld_valid = 1'b0; flush_req = 1'b1;
    w0 = wr_cnt;
    samp();
    chk("t5_st_ready_req", 32'(st_ready), 32'd1);
    chk("t5_done_req", 32'(flush_done), 32'd0);
    tick();
    flush_req = 1'b0;
    store(32'h200, 32'hEE, 32'h600);
    for (int f = 1; f <= 3; f++) begin
      samp();
      chk("t5_st_ready_flush", 32'(st_ready), 32'd0);
      chk("t5_done_flush", 32'(flush_done), 32'd0);
      tick();
    end
    samp();
    chk("t5_done_pulse", 32'(flush_done), 32'd1);
    chk("t5_st_ready_done", 32'(st_ready), 32'd0);
    tick();
    st_valid = 1'b0;
    samp();
    chk("t5_done_clear", 32'(flush_done), 32'd0);
    chk("t5_st_ready_back", 32'(st_ready), 32'd1);
    chk("t5_writes", 32'(wr_cnt - w0), 32'd3);
    tick();

    // Flush of an empty buffer with flush_req held until DONE
    flush_req = 1'b1;
    samp(); chk("t5e_done0", 32'(flush_done), 32'd0); tick();
    samp(); chk("t5e_done1", 32'(flush_done), 32'd0); tick();
    samp(); chk("t5e_done2", 32'(flush_done), 32'd1); tick();
    flush_req = 1'b0;
    samp();
    chk("t5e_done3", 32'(flush_done), 32'd0);
    chk("t5e_st_ready", 32'(st_ready), 32'd1);
    tick();

    // Reset in the middle of a drain
    ld_valid = 1'b1; ld_addr = 32'h40;
    store(32'hE0, 32'h90, 32'h700);
    samp(); tick();
    store(32'hE4, 32'h91, 32'h704);
    samp(); tick();
    st_valid = 1'b0; ld_valid = 1'b0;
    samp();
    chk("t6_wr_before", 32'(dm_MemWrite), 32'd1);
    chk("t6_count_before", 32'(count), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_count_rst", 32'(count), 32'd0);
    chk("t6_wr_rst", 32'(dm_MemWrite), 32'd0);
    chk("t6_empty_rst", 32'(empty), 32'd1);
    chk("t6_st_ready_rst", 32'(st_ready), 32'd1);
    sb_q.delete();
    w0 = wr_cnt;
    tick(); tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      samp();
      chk("t6_no_write", 32'(dm_MemWrite), 32'd0);
      tick();
    end
    chk("t6_wr_count", 32'(wr_cnt - w0), 32'd0);
    chk("t6_mem_untouched", dmem[56], 32'h0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
